// File: rtl/reflet_timer_if.sv
// CPU-side bus bundle for the reflet timer: chip select, word address,
// write data/strobe, registered read data and the interrupt line.
interface reflet_timer_if #(
  parameter int unsigned wordsize = 16
);
  logic                enable;
  logic [2:0]          addr;
  logic [wordsize-1:0] data_in;
  logic                write_en;
  logic [wordsize-1:0] data_out;
  logic                interrupt;

  modport master (
    output enable, addr, data_in, write_en,
    input  data_out, interrupt
  );

  modport slave (
    input  enable, addr, data_in, write_en,
    output data_out, interrupt
  );
endinterface

// File: rtl/reflet_timer.sv
// Memory-mapped down-counting timer with prescaler, reload and a stretched
// interrupt pulse; read data is zero when not selected so it can be OR-muxed.
module reflet_timer #(
  parameter int unsigned wordsize = 16,
  parameter int unsigned irq_len  = 2
) (
  input  logic         clk,
  input  logic         reset,
  reflet_timer_if.slave bus
);
  localparam int unsigned irq_w = 4;
  localparam logic [2:0] a_ctrl     = 3'd0;
  localparam logic [2:0] a_prescale = 3'd1;
  localparam logic [2:0] a_reload   = 3'd2;
  localparam logic [2:0] a_count    = 3'd3;
  localparam logic [2:0] a_status   = 3'd4;

  logic                run, auto_reload, irq_en, pending, irq_out;
  logic [wordsize-1:0] prescale, reload, count, psc_cnt, rd_data;
  logic [irq_w-1:0]    irq_cnt;

  logic                run_nx, auto_reload_nx, irq_en_nx, pending_nx, irq_out_nx;
  logic [wordsize-1:0] prescale_nx, reload_nx, count_nx, psc_cnt_nx, rd_data_nx;
  logic [irq_w-1:0]    irq_cnt_nx;

  logic wr, rd, ctrl_wr, count_wr, status_wr, run_clr, tick, tick_eff, underflow;

  assign wr        = bus.enable & bus.write_en;
  assign rd        = bus.enable & ~bus.write_en;
  assign ctrl_wr   = wr && (bus.addr == a_ctrl);
  assign count_wr  = wr && (bus.addr == a_count);
  assign status_wr = wr && (bus.addr == a_status);
  // A CTRL write that stops the timer also swallows a tick due this cycle.
  assign run_clr   = ctrl_wr && !bus.data_in[0];
  assign tick      = run && (psc_cnt == prescale) && !run_clr;
  // A CPU write to COUNT overrides whatever the tick would have done.
  assign tick_eff  = tick && !count_wr;
  assign underflow = tick_eff && (count == '0);

  // Next-state and read-data computation
  always_comb begin
    run_nx         = run;
    auto_reload_nx = auto_reload;
    irq_en_nx      = irq_en;
    prescale_nx    = prescale;
    reload_nx      = reload;
    count_nx       = count;
    pending_nx     = pending;
    psc_cnt_nx     = psc_cnt;
    irq_cnt_nx     = irq_cnt;
    rd_data_nx     = '0;

    if (ctrl_wr && bus.data_in[0]) begin
      psc_cnt_nx = '0;
    end else if (run && !run_clr) begin
      psc_cnt_nx = (psc_cnt == prescale) ? '0 : psc_cnt + wordsize'(1);
    end

    if (tick_eff) begin
      if (count != '0) begin
        count_nx = count - wordsize'(1);
      end else if (auto_reload) begin
        count_nx = reload;
      end else begin
        run_nx = 1'b0;
      end
    end

    if (wr) begin
      case (bus.addr)
        a_ctrl: begin
          run_nx         = bus.data_in[0];
          auto_reload_nx = bus.data_in[1];
          irq_en_nx      = bus.data_in[2];
        end
        a_prescale: prescale_nx = bus.data_in;
        a_reload:   reload_nx   = bus.data_in;
        a_count:    count_nx    = bus.data_in;
        default:    ;
      endcase
    end

    // Set beats clear when an underflow coincides with a STATUS write.
    if (underflow) begin
      pending_nx = 1'b1;
    end else if (status_wr && bus.data_in[0]) begin
      pending_nx = 1'b0;
    end

    if (underflow && irq_en) begin
      irq_cnt_nx = irq_w'(irq_len);
    end else if (irq_cnt != '0) begin
      irq_cnt_nx = irq_cnt - irq_w'(1);
    end
    irq_out_nx = (irq_cnt_nx != '0);

    if (rd) begin
      case (bus.addr)
        a_ctrl:     rd_data_nx = wordsize'({irq_en, auto_reload, run});
        a_prescale: rd_data_nx = prescale;
        a_reload:   rd_data_nx = reload;
        a_count:    rd_data_nx = count;
        a_status:   rd_data_nx = wordsize'(pending);
        default:    rd_data_nx = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run         <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      prescale    <= '0;
      reload      <= '0;
      count       <= '0;
      pending     <= 1'b0;
      psc_cnt     <= '0;
      irq_cnt     <= '0;
      irq_out     <= 1'b0;
      rd_data     <= '0;
    end else begin
      run         <= run_nx;
      auto_reload <= auto_reload_nx;
      irq_en      <= irq_en_nx;
      prescale    <= prescale_nx;
      reload      <= reload_nx;
      count       <= count_nx;
      pending     <= pending_nx;
      psc_cnt     <= psc_cnt_nx;
      irq_cnt     <= irq_cnt_nx;
      irq_out     <= irq_out_nx;
      rd_data     <= rd_data_nx;
    end
  end

  assign bus.data_out  = rd_data;
  assign bus.interrupt = irq_out;
endmodule

// File: tb/tb_reflet_timer.sv
// Directed bench for reflet_timer: bus ops are driven on the falling edge,
// so each read returns the data captured at the following rising edge.
module tb_reflet_timer;
  logic clk;
  logic reset;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  reflet_timer_if #(.wordsize(16)) bus ();

  reflet_timer #(.wordsize(16), .irq_len(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.enable   = 1'b1;
    bus.write_en = 1'b1;
    bus.addr     = a;
    bus.data_in  = d;
    @(negedge clk);
    bus.enable   = 1'b0;
    bus.write_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] v);
    bus.enable   = 1'b1;
    bus.write_en = 1'b0;
    bus.addr     = a;
    @(negedge clk);
    v = bus.data_out;
    bus.enable = 1'b0;
  endtask

  task automatic wait_rise(input int bound, output int t, output logic ok);
    logic prev;
    prev = bus.interrupt;
    ok   = 1'b0;
    t    = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (!prev && bus.interrupt) begin
        ok = 1'b1;
        t  = cyc;
      end
      prev = bus.interrupt;
    end
  endtask

  initial begin
    logic [15:0] v;
    logic        ok;
    int          t [4];
    int          c0, n;

    bus.enable = 1'b0; bus.write_en = 1'b0; bus.addr = '0; bus.data_in = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_dout", 32'(bus.data_out), 32'h0);
    check("rst_irq",  32'(bus.interrupt), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      check("rst_read", 32'(v), 32'h0);
    end

    // Periodic: PRESCALE=0, RELOAD=3, run|auto|irq_en
    wr(3'd1, 16'd0);
    wr(3'd2, 16'd3);
    wr(3'd0, 16'd7);
    check("per_irq_start", 32'(bus.interrupt), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("per_irq", 32'(bus.interrupt), 32'(((k - 1) % 4) < 2));
    end
    for (int k = 0; k < 4; k++) begin
      rd(3'd3, v);
      check("per_count", 32'(v), 32'(3 - k));
    end

    // Asynchronous reset in the middle of a pulse
    wait_rise(20, c0, ok);
    check("per_rise_seen", 32'(ok), 32'h1);
    rd(3'd2, v);
    check("mid_reload", 32'(v), 32'd3);
    check("mid_irq", 32'(bus.interrupt), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async_dout", 32'(bus.data_out), 32'h0);
    check("async_irq",  32'(bus.interrupt), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rd(3'd0, v);
    check("post_rst_ctrl", 32'(v), 32'h0);
    rd(3'd3, v);
    check("post_rst_count", 32'(v), 32'h0);

    // Prescaled: period (4+1)*(9+1) = 50
    wr(3'd1, 16'd4);
    wr(3'd2, 16'd9);
    wr(3'd0, 16'd7);
    for (int i = 0; i < 4; i++) begin
      wait_rise(200, t[i], ok);
      check("psc_rise_seen", 32'(ok), 32'h1);
    end
    for (int i = 1; i < 4; i++) check("psc_period", 32'(t[i] - t[i-1]), 32'd50);
    rd(3'd4, v);
    check("psc_status", 32'(v), 32'h1);
    wr(3'd0, 16'd0);
    wr(3'd4, 16'd1);
    rd(3'd4, v);
    check("psc_status_clr", 32'(v), 32'h0);

    // One-shot: PRESCALE=1, COUNT=5, run|irq_en -> pulse 12 cycles after write
    wr(3'd1, 16'd1);
    wr(3'd3, 16'd5);
    wr(3'd0, 16'd5);
    c0 = cyc;
    wait_rise(50, t[0], ok);
    check("os_rise_seen", 32'(ok), 32'h1);
    check("os_delay", 32'(t[0] - c0), 32'd12);
    rd(3'd0, v);
    check("os_ctrl", 32'(v), 32'h4);
    check("os_width", 32'(bus.interrupt), 32'h1);
    rd(3'd3, v);
    check("os_count", 32'(v), 32'h0);
    n = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.interrupt) n++;
    end
    check("os_quiet", 32'(n), 32'h0);

    // Pending with irq_en=0
    wr(3'd4, 16'd1);
    wr(3'd1, 16'd0);
    wr(3'd3, 16'd0);
    wr(3'd0, 16'd1);
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.interrupt) n++;
    end
    check("pend_no_irq", 32'(n), 32'h0);
    rd(3'd4, v);
    check("pend_set", 32'(v), 32'h1);
    wr(3'd4, 16'd0);
    check("wr_dout_zero", 32'(bus.data_out), 32'h0);
    rd(3'd4, v);
    check("pend_wr0", 32'(v), 32'h1);
    wr(3'd4, 16'd1);
    rd(3'd4, v);
    check("pend_clr", 32'(v), 32'h0);

    // STATUS clear landing on the underflow edge: set wins
    wr(3'd3, 16'd2);
    wr(3'd0, 16'd1);
    @(negedge clk);
    @(negedge clk);
    wr(3'd4, 16'd1);
    rd(3'd4, v);
    check("pend_set_wins", 32'(v), 32'h1);

    // COUNT write in a tick cycle (which would otherwise underflow/reload)
    wr(3'd4, 16'd1);
    wr(3'd2, 16'd3);
    wr(3'd3, 16'd0);
    wr(3'd0, 16'd3);
    wr(3'd3, 16'd7);
    rd(3'd3, v);
    check("wr_vs_tick", 32'(v), 32'd7);
    rd(3'd4, v);
    check("wr_vs_tick_pend", 32'(v), 32'h0);
    wr(3'd0, 16'd0);

    // Unmapped addresses and reserved CTRL bits
    wr(3'd6, 16'hffff);
    rd(3'd6, v);
    check("addr6", 32'(v), 32'h0);
    rd(3'd5, v);
    check("addr5", 32'(v), 32'h0);
    rd(3'd7, v);
    check("addr7", 32'(v), 32'h0);
    wr(3'd0, 16'hfffe);
    rd(3'd0, v);
    check("ctrl_bits", 32'(v), 32'h6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
